// File: rtl/lcd_16207_responder.sv
// HD44780-compatible device-side responder for the 16207 character LCD bus.
// Busy-flag timing is modelled only when LCD_RESPONDER_BUSY_EN is defined.
module lcd_16207_responder #(
   parameter int BUSY_CYCLES  = 40,
   parameter int CLEAR_CYCLES = 1600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       LCD_E,
   input  logic       LCD_RS,
   input  logic       LCD_RW,
   input  logic [7:0] LCD_data_in,
   output logic [7:0] LCD_data_out,
   output logic       LCD_data_oe,
   input  logic [6:0] dbg_addr,
   output logic [7:0] dbg_char,
   output logic [6:0] ac,
   output logic       busy,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       protocol_err
);
`ifdef LCD_RESPONDER_BUSY_EN
   localparam bit BUSY_EN = 1'b1;
`else
   localparam bit BUSY_EN = 1'b0;
`endif
   localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
   localparam int CW         = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);
   // With busy modelling off both loads are zero, so the counter folds to a constant.
   localparam logic [CW-1:0] SHORT_LOAD = BUSY_EN ? CW'(BUSY_CYCLES)  : '0;
   localparam logic [CW-1:0] LONG_LOAD  = BUSY_EN ? CW'(CLEAR_CYCLES) : '0;

   logic [7:0]    ddram [80];
   logic [CW-1:0] busy_cnt;
   logic          e_q, inc_mode, cg_mode;
   logic          fall, accept, ac_valid, long_instr;
   logic [6:0]    ac_idx, dbg_idx;
   logic [7:0]    rd_data;

   function automatic logic addr_valid(input logic [6:0] a);
      return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
   endfunction

   // Line 2 (0x40-0x67) packs directly after line 1 in the 80-entry array.
   function automatic logic [6:0] addr_index(input logic [6:0] a);
      return a[6] ? (a - 7'd24) : a;
   endfunction

   function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
      if (up) begin
         if (a == 7'h27) return 7'h40;
         if (a == 7'h67) return 7'h00;
         return a + 7'd1;
      end
      if (a == 7'h00) return 7'h67;
      if (a == 7'h40) return 7'h27;
      return a - 7'd1;
   endfunction

   assign busy = (busy_cnt != '0);

   // NOTE: every signal written here gets a value on every path, so no latch is inferred.
   always_comb begin
      fall       = e_q && !LCD_E;
      accept     = fall && (!busy || (!LCD_RS && LCD_RW));
      ac_valid   = addr_valid(ac);
      ac_idx     = addr_index(ac);
      dbg_idx    = addr_index(dbg_addr);
      long_instr = (LCD_data_in[7:2] == 6'd0) && (LCD_data_in[1:0] != 2'd0);
      rd_data    = {busy, ac};
      if (LCD_RS)
         rd_data = (ac_valid && !cg_mode) ? ddram[ac_idx] : 8'h00;
      dbg_char   = addr_valid(dbg_addr) ? ddram[dbg_idx] : 8'h00;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_q          <= 1'b0;
         ac           <= 7'h00;
         inc_mode     <= 1'b1;
         cg_mode      <= 1'b0;
         display_on   <= 1'b0;
         cursor_on    <= 1'b0;
         blink_on     <= 1'b0;
         protocol_err <= 1'b0;
         busy_cnt     <= '0;
         LCD_data_oe  <= 1'b0;
         LCD_data_out <= 8'h00;
         // NOTE: DDRAM is a register array, not a RAM macro, because reset and clear fill it in one cycle.
         for (int i = 0; i < 80; i++) ddram[i] <= 8'h20;
      end else begin
         e_q          <= LCD_E;
         LCD_data_oe  <= LCD_E && LCD_RW;
         LCD_data_out <= (LCD_E && LCD_RW) ? rd_data : 8'h00;

         if (accept && !LCD_RW)
            busy_cnt <= (!LCD_RS && long_instr) ? LONG_LOAD : SHORT_LOAD;
         else if (busy)
            busy_cnt <= busy_cnt - 1'b1;

         if (fall && !accept)
            protocol_err <= 1'b1;

         if (accept) begin
            if (LCD_RW) begin
               if (LCD_RS) ac <= ac_step(ac, inc_mode);
            end else if (LCD_RS) begin
               if (ac_valid && !cg_mode) ddram[ac_idx] <= LCD_data_in;
               ac <= ac_step(ac, inc_mode);
            end else begin
               // Entry-mode S and function-set bits have no observable effect and are not held.
               casez (LCD_data_in)
                  8'b1???????: begin
                     ac      <= LCD_data_in[6:0];
                     cg_mode <= 1'b0;
                  end
                  8'b01??????: cg_mode <= 1'b1;
                  8'b001?????: begin end
                  8'b0001????: if (!LCD_data_in[3]) ac <= ac_step(ac, LCD_data_in[2]);
                  8'b00001???: begin
                     display_on <= LCD_data_in[2];
                     cursor_on  <= LCD_data_in[1];
                     blink_on   <= LCD_data_in[0];
                  end
                  8'b000001??: inc_mode <= LCD_data_in[1];
                  8'b0000001?: ac <= 7'h00;
                  8'b00000001: begin
                     for (int i = 0; i < 80; i++) ddram[i] <= 8'h20;
                     ac       <= 7'h00;
                     inc_mode <= 1'b1;
                  end
                  default: begin end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_lcd_16207_responder.sv
// Self-checking bench for lcd_16207_responder: directed test-plan steps plus a randomized phase,
// checked against an address-level model of the display controller.
module tb_lcd_16207_responder;
`ifdef LCD_RESPONDER_BUSY_EN
   localparam bit BUSY_EN = 1'b1;
`else
   localparam bit BUSY_EN = 1'b0;
`endif
   localparam int BUSY_CYCLES  = 40;
   localparam int CLEAR_CYCLES = 1600;

   logic       clk = 1'b0;
   logic       reset, LCD_E, LCD_RS, LCD_RW;
   logic [7:0] LCD_data_in, LCD_data_out, dbg_char;
   logic       LCD_data_oe, busy, display_on, cursor_on, blink_on, protocol_err;
   logic [6:0] dbg_addr, ac;

   lcd_16207_responder #(.BUSY_CYCLES(BUSY_CYCLES), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
      .clk(clk), .reset(reset), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
      .LCD_data_in(LCD_data_in), .LCD_data_out(LCD_data_out), .LCD_data_oe(LCD_data_oe),
      .dbg_addr(dbg_addr), .dbg_char(dbg_char), .ac(ac), .busy(busy),
      .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
      .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: memory indexed directly by bus address, busy as an end-cycle stamp.
   logic [7:0] m_ram [128];
   logic [6:0] m_ac;
   bit         m_inc, m_cg, m_disp, m_cur, m_blink, m_perr;
   int         m_busy_end;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit m_valid(input logic [6:0] a);
      return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
   endfunction

   // Step through the 80 cells as one circular sequence; invalid addresses step mod 128.
   function automatic logic [6:0] m_step(input logic [6:0] a, input bit up);
      int p;
      if (!m_valid(a)) return up ? a + 7'd1 : a - 7'd1;
      p = (a < 7'h40) ? int'(a) : int'(a) - 64 + 40;
      p = up ? (p + 1) % 80 : (p + 79) % 80;
      return (p < 40) ? 7'(p) : 7'(p + 24);
   endfunction

   function automatic bit m_busy();
      return BUSY_EN && (cyc < m_busy_end);
   endfunction

   function automatic logic [7:0] m_read(input bit rs);
      if (!rs) return {m_busy(), m_ac};
      return (m_valid(m_ac) && !m_cg) ? m_ram[m_ac] : 8'h00;
   endfunction

   function automatic void model_reset();
      for (int a = 0; a < 128; a++) m_ram[a] = 8'h20;
      m_ac = 7'h00; m_inc = 1'b1; m_cg = 1'b0;
      m_disp = 1'b0; m_cur = 1'b0; m_blink = 1'b0; m_perr = 1'b0;
      m_busy_end = 0;
   endfunction

   function automatic void model_event(input bit rs, input bit rw, input logic [7:0] d, input bit pre_busy);
      if (pre_busy && !(!rs && rw)) begin
         m_perr = 1'b1;
         return;
      end
      if (rw) begin
         if (rs) m_ac = m_step(m_ac, m_inc);
         return;
      end
      m_busy_end = cyc + ((!rs && d >= 8'h01 && d <= 8'h03) ? CLEAR_CYCLES : BUSY_CYCLES);
      if (rs) begin
         if (m_valid(m_ac) && !m_cg) m_ram[m_ac] = d;
         m_ac = m_step(m_ac, m_inc);
      end else if (d >= 8'h80) begin
         m_ac = d[6:0]; m_cg = 1'b0;
      end else if (d >= 8'h40) begin
         m_cg = 1'b1;
      end else if (d >= 8'h20) begin
      end else if (d >= 8'h10) begin
         if (!d[3]) m_ac = m_step(m_ac, d[2]);
      end else if (d >= 8'h08) begin
         m_disp = d[2]; m_cur = d[1]; m_blink = d[0];
      end else if (d >= 8'h04) begin
         m_inc = d[1];
      end else if (d >= 8'h02) begin
         m_ac = 7'h00;
      end else if (d == 8'h01) begin
         for (int a = 0; a < 128; a++) m_ram[a] = 8'h20;
         m_ac = 7'h00; m_inc = 1'b1;
      end
   endfunction

   task automatic check_state(input string tag);
      check({tag, "_ac"}, {1'b0, ac}, {1'b0, m_ac});
      check({tag, "_busy"}, {7'd0, busy}, {7'd0, m_busy()});
      check({tag, "_perr"}, {7'd0, protocol_err}, {7'd0, m_perr});
      check({tag, "_disp"}, {5'd0, display_on, cursor_on, blink_on}, {5'd0, m_disp, m_cur, m_blink});
      check({tag, "_oe"}, {7'd0, LCD_data_oe}, 8'h00);
   endtask

   // One full E pulse: high for one sampled cycle, falling edge on the next.
   task automatic access(input bit rs, input bit rw, input logic [7:0] d, input string tag);
      logic [7:0] exp_rd;
      bit         pre_busy;
      exp_rd = m_read(rs);
      LCD_RS = rs; LCD_RW = rw; LCD_data_in = d; LCD_E = 1'b1;
      tick();
      if (rw) begin
         check({tag, "_rd_oe"}, {7'd0, LCD_data_oe}, 8'h01);
         check({tag, "_rd"}, LCD_data_out, exp_rd);
      end
      LCD_E = 1'b0;
      pre_busy = m_busy();
      tick();
      model_event(rs, rw, d, pre_busy);
      check_state(tag);
   endtask

   task automatic wait_idle();
      while (m_busy()) tick();
      check("idle_busy", {7'd0, busy}, 8'h00);
   endtask

   task automatic measure_busy(input string tag, input int expected);
      int n = 0;
      while (busy === 1'b1 && n < 4000) begin
         tick();
         n++;
      end
      check(tag, 8'(n), 8'(expected));
   endtask

   task automatic check_ram(input logic [6:0] a, input logic [7:0] exp, input string tag);
      dbg_addr = a;
      #1;
      check(tag, dbg_char, exp);
   endtask

   task automatic sweep(input string tag);
      for (int a = 0; a < 128; a++) begin
         dbg_addr = 7'(a);
         @(negedge clk);
         check(tag, dbg_char, m_valid(7'(a)) ? m_ram[a] : 8'h00);
      end
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1; LCD_E = 1'b0;
      tick();
      tick();
      model_reset();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      logic [7:0] rb;
      int         op, r;
      reset = 1'b1; LCD_E = 1'b0; LCD_RS = 1'b0; LCD_RW = 1'b0;
      LCD_data_in = 8'h00; dbg_addr = 7'h00;

      do_reset();
      check("rst_ac", {1'b0, ac}, 8'h00);
      check("rst_busy", {7'd0, busy}, 8'h00);
      check("rst_perr", {7'd0, protocol_err}, 8'h00);
      check("rst_oe", {7'd0, LCD_data_oe}, 8'h00);
      check("rst_dout", LCD_data_out, 8'h00);
      check("rst_disp", {5'd0, display_on, cursor_on, blink_on}, 8'h00);
      sweep("rst_ram");

      access(1'b0, 1'b0, 8'h80, "set_00");
      measure_busy("busy_len_instr", BUSY_EN ? BUSY_CYCLES : 0);
      access(1'b1, 1'b0, 8'h31, "wr_31");
      measure_busy("busy_len_data", BUSY_EN ? BUSY_CYCLES : 0);
      access(1'b1, 1'b0, 8'h32, "wr_32");
      wait_idle();
      check_ram(7'h00, 8'h31, "ram_00");
      check_ram(7'h01, 8'h32, "ram_01");
      check("ac_02", {1'b0, ac}, 8'h02);

      access(1'b0, 1'b0, 8'hA7, "set_27"); wait_idle();
      access(1'b1, 1'b0, 8'h41, "wr_41");  wait_idle();
      check_ram(7'h27, 8'h41, "ram_27");
      check("ac_wrap_up", {1'b0, ac}, 8'h40);
      access(1'b0, 1'b0, 8'h04, "entry_dec"); wait_idle();
      access(1'b0, 1'b0, 8'hC0, "set_40");    wait_idle();
      access(1'b1, 1'b0, 8'h42, "wr_42");     wait_idle();
      check_ram(7'h40, 8'h42, "ram_40");
      check("ac_wrap_dn", {1'b0, ac}, 8'h27);

      access(1'b0, 1'b0, 8'h01, "clear");
      access(1'b0, 1'b1, 8'h00, "stat_clr");
      check("stat_clr_lit", LCD_data_out, 8'h00);
      wait_idle();
      access(1'b0, 1'b1, 8'h00, "stat_idle");
      sweep("clr_ram");

      access(1'b0, 1'b0, 8'h80, "set_00b"); wait_idle();
      access(1'b1, 1'b0, 8'h31, "wr_31b");  wait_idle();
      access(1'b1, 1'b0, 8'h32, "wr_32b");
      access(1'b1, 1'b0, 8'h77, "wr_busy");
      wait_idle();
      check_ram(7'h01, 8'h32, "ram_01b");
      check_ram(7'h02, m_ram[2], "ram_02b");
      access(1'b0, 1'b0, 8'h81, "set_01"); wait_idle();
      access(1'b1, 1'b1, 8'h00, "rd_01");
      check("ac_after_rd", {1'b0, ac}, 8'h02);

      access(1'b0, 1'b0, 8'h90, "b2b_set");
      for (int i = 0; i < 5; i++) access(1'b1, 1'b0, 8'(8'h61 + i), "b2b_wr");
      wait_idle();
      for (int i = 0; i < 5; i++) check_ram(7'(7'h10 + i), m_ram[7'h10 + i], "b2b_ram");

      access(1'b1, 1'b0, 8'h99, "pre_rst_wr");
      do_reset();
      check_state("rst_mid_busy");
      sweep("rst_mid_ram");

      LCD_RS = 1'b1; LCD_RW = 1'b1; LCD_E = 1'b1;
      tick();
      check("rd_oe_hi", {7'd0, LCD_data_oe}, 8'h01);
      reset = 1'b1; LCD_E = 1'b0;
      tick();
      model_reset();
      reset = 1'b0;
      check("rst_rd_oe", {7'd0, LCD_data_oe}, 8'h00);
      check("rst_rd_dout", LCD_data_out, 8'h00);
      tick();
      check_state("rst_rd_fall");
      LCD_RS = 1'b1; LCD_RW = 1'b0; LCD_data_in = 8'h55; LCD_E = 1'b1;
      tick();
      reset = 1'b1; LCD_E = 1'b0;
      tick();
      model_reset();
      reset = 1'b0;
      tick();
      check_state("rst_wr_fall");
      check_ram(7'h00, 8'h20, "rst_wr_ram");

      for (int k = 0; k < 150; k++) begin
         op = $urandom_range(0, 9);
         rb = 8'($urandom);
         if (op != 6) wait_idle();
         if (op <= 3) access(1'b1, 1'b0, rb, "rnd_wr");
         else if (op <= 5) access(1'b1, 1'b1, 8'h00, "rnd_rd");
         else if (op == 6) access(1'b0, 1'b1, 8'h00, "rnd_stat");
         else begin
            r = $urandom_range(0, 15);
            if (r <= 4) rb = 8'h80 | ($urandom_range(0, 1) ? 8'($urandom_range(0, 39))
                                                             : 8'($urandom_range(64, 103)));
            else if (r == 5) rb = 8'h80 | 8'($urandom_range(0, 127));
            else if (r <= 7) rb = 8'h10 | 8'($urandom_range(0, 15));
            else if (r == 8) rb = 8'h04 | 8'($urandom_range(0, 3));
            else if (r == 9) rb = 8'h08 | 8'($urandom_range(0, 7));
            else if (r == 10) rb = 8'h20 | 8'($urandom_range(0, 31));
            else if (r == 11) rb = 8'h40 | 8'($urandom_range(0, 63));
            else if (r == 12) rb = 8'h02 | 8'($urandom_range(0, 1));
            else if (r == 13) rb = 8'h01;
            else if (r == 14) rb = 8'h00;
            access(1'b0, 1'b0, rb, "rnd_ins");
         end
      end
      wait_idle();
      sweep("final_ram");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
